// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multi-cycle RISC-V control unit:
// FSM state encoding, decoded opcodes and ALU operation selects.
package ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        MEM_ADDR = 4'd4,
        MEM_RD   = 4'd5,
        MEM_WR   = 4'd6,
        WB_ALU   = 4'd7,
        WB_MEM   = 4'd8,
        TRAP     = 4'd9,
        ERROR    = 4'd10
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_STORE = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // States in which the controller waits on the data memory handshake.
    function automatic logic is_mem_state(input state_t s);
        return (s == MEM_RD) || (s == MEM_WR);
    endfunction

endpackage

// File: rtl/ctrl_timeout_cnt.sv
// Memory-wait timeout counter: held clear outside the memory states,
// counts wait cycles, saturates at LIMIT and flags the cycle on which the
// limit would be reached without a ready. LIMIT = 0 disables expiry.
module ctrl_timeout_cnt #(
    parameter int LIMIT = 16,
    parameter int W     = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expired
);

    localparam logic [W-1:0] LIM_W    = W'(LIMIT);
    localparam logic [W-1:0] LIM_M1_W = W'(LIMIT - 1);

    logic [W-1:0] r_cnt;

    // Clear / saturating increment of the wait-cycle count.
    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != LIM_W)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    generate
        if (LIMIT == 0) begin : g_no_timeout
            assign o_expired = 1'b0;
        end else begin : g_timeout
            // This wait cycle is the LIMIT-th one without a ready.
            assign o_expired = i_inc && (r_cnt >= LIM_M1_W);
        end
    endgenerate

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM for the RISC-V datapath (R-type, I-type ALU, lw,
// sw; everything else traps). Fetch/memory ready handshakes, memory
// timeout with sticky error state.
// Optional: define MULTICYCLE_CTRL_PERF_EN to add cycle_cnt / instr_cnt.
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  Opcode,
    input  logic        instr_valid,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        IRWrite,
    output logic        ALUSrc,
    output logic        MemtoReg,
    output logic        RegWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [1:0]  ALUOp,
    output logic        illegal_op,
    output logic        mem_err,
    output logic [3:0]  state_o
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt
`endif
);

    localparam int TO_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

    state_t     r_state;
    state_t     w_next;
    logic [6:0] r_opcode;
    logic       w_in_mem;
    logic       w_expired;

    assign w_in_mem = is_mem_state(r_state);
    assign state_o  = r_state;

    ctrl_timeout_cnt #(
        .LIMIT (MEM_TIMEOUT),
        .W     (TO_W)
    ) u_timeout (
        .clk       (clk),
        .reset     (reset),
        .i_clr     (~w_in_mem),
        .i_inc     (w_in_mem & ~mem_ready),
        .o_expired (w_expired)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Opcode is captured only in DECODE; later changes on the input are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_opcode <= '0;
        end else if (r_state == DECODE) begin
            r_opcode <= Opcode;
        end
    end

    // Next-state and control decode from registered state and opcode.
    always_comb begin
        w_next     = r_state;
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        ALUSrc     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        ALUOp      = ALUOP_ADD;
        illegal_op = 1'b0;
        mem_err    = 1'b0;
        case (r_state)
            FETCH: begin
                IRWrite = instr_valid;
                if (instr_valid) w_next = DECODE;
            end
            DECODE: begin
                case (Opcode)
                    OP_R:              w_next = EXEC_R;
                    OP_I:              w_next = EXEC_I;
                    OP_LOAD, OP_STORE: w_next = MEM_ADDR;
                    default:           w_next = TRAP;
                endcase
            end
            EXEC_R: begin
                ALUOp  = ALUOP_FUNCT;
                w_next = WB_ALU;
            end
            EXEC_I: begin
                ALUSrc = 1'b1;
                ALUOp  = ALUOP_FUNCT;
                w_next = WB_ALU;
            end
            MEM_ADDR: begin
                ALUSrc = 1'b1;
                ALUOp  = (r_opcode == OP_STORE) ? ALUOP_STORE : ALUOP_ADD;
                w_next = (r_opcode == OP_STORE) ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                ALUSrc  = 1'b1;
                MemRead = 1'b1;
                // A ready on the limit cycle still completes the access.
                if (mem_ready)      w_next = WB_MEM;
                else if (w_expired) w_next = ERROR;
            end
            MEM_WR: begin
                ALUSrc   = 1'b1;
                MemWrite = 1'b1;
                PCWrite  = mem_ready;
                if (mem_ready)      w_next = FETCH;
                else if (w_expired) w_next = ERROR;
            end
            WB_ALU: begin
                RegWrite = 1'b1;
                PCWrite  = 1'b1;
                w_next   = FETCH;
            end
            WB_MEM: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                PCWrite  = 1'b1;
                w_next   = FETCH;
            end
            TRAP:    illegal_op = 1'b1;
            ERROR:   mem_err    = 1'b1;
            default: w_next     = FETCH;
        endcase
    end

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_instr_cnt;

    // Free-running cycle and retired-instruction counters, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycle_cnt <= '0;
            r_instr_cnt <= '0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
            if (PCWrite) r_instr_cnt <= r_instr_cnt + 32'd1;
        end
    end

    assign cycle_cnt = r_cycle_cnt;
    assign instr_cnt = r_instr_cnt;
`endif

endmodule
